// File: rtl/cpu_exec_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_exec_core_if
//  Description : Instruction/operand inputs, PC/ALU outputs, control bits and
//                condition flags of the execution core, bundled as one bus.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cpu_exec_core_if;
    logic [31:0] inst;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] pc;
    logic [63:0] alu_result;
    logic        reg_write;
    logic        reg2loc;
    logic        alu_src;
    logic        set_flags;
    logic        mem_write;
    logic        mem_read;
    logic        mem_to_reg;
    logic        br_taken;
    logic [2:0]  alu_cntrl;
    logic        flag_n;
    logic        flag_z;
    logic        flag_v;
    logic        flag_c;

    // Fetch/register-file side: supplies instruction and operands, observes results
    modport master (
        output inst, rd1, rd2,
        input  pc, alu_result, reg_write, reg2loc, alu_src, set_flags,
        input  mem_write, mem_read, mem_to_reg, br_taken, alu_cntrl,
        input  flag_n, flag_z, flag_v, flag_c
    );

    // Execution core side
    modport slave (
        input  inst, rd1, rd2,
        output pc, alu_result, reg_write, reg2loc, alu_src, set_flags,
        output mem_write, mem_read, mem_to_reg, br_taken, alu_cntrl,
        output flag_n, flag_z, flag_v, flag_c
    );
endinterface
`default_nettype wire

// File: rtl/cpu_exec_core.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_exec_core
//  Description : Single-cycle execution core for a small ARMv8 subset:
//                decode, 64-bit ALU with N/Z/V/C, registered flags and PC
//                with branch handling.
//                Optional feature macro: CPU_EXEC_CORE_ANDS_EN (decodes ANDS).
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_exec_core #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic              clk,
    input  logic              reset,
    cpu_exec_core_if.slave    bus
);

    // Opcode fields
    localparam logic [9:0]  c_OP_ADDI  = 10'b1001000100;
    localparam logic [10:0] c_OP_ADDS  = 11'b10101011000;
    localparam logic [10:0] c_OP_SUBS  = 11'b11101011000;
    localparam logic [10:0] c_OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] c_OP_STUR  = 11'b11111000000;
`ifdef CPU_EXEC_CORE_ANDS_EN
    localparam logic [10:0] c_OP_ANDS  = 11'b11101010000;
`endif
    localparam logic [5:0]  c_OP_B     = 6'b000101;
    localparam logic [7:0]  c_OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  c_OP_BCOND = 8'b01010100;
    localparam logic [4:0]  c_COND_LT  = 5'b01011;

    // ALU operation codes
    localparam logic [2:0]  c_ALU_PASSB = 3'b000;
    localparam logic [2:0]  c_ALU_ADD   = 3'b010;
    localparam logic [2:0]  c_ALU_SUB   = 3'b011;
    localparam logic [2:0]  c_ALU_AND   = 3'b100;
    localparam logic [2:0]  c_ALU_ORR   = 3'b101;
    localparam logic [2:0]  c_ALU_EOR   = 3'b110;

    // Registered state
    logic [63:0] r_pc;
    logic        r_flag_n;
    logic        r_flag_z;
    logic        r_flag_v;
    logic        r_flag_c;

    // Decode results
    logic        w_reg_write;
    logic        w_reg2loc;
    logic        w_alu_src;
    logic        w_set_flags;
    logic        w_mem_write;
    logic        w_mem_read;
    logic        w_mem_to_reg;
    logic [2:0]  w_alu_cntrl;
    logic [63:0] w_imm;
    logic [63:0] w_offset;
    logic        w_is_b;
    logic        w_is_cbz;
    logic        w_is_blt;

    // ALU datapath
    logic [63:0] w_a;
    logic [63:0] w_b;
    logic [64:0] w_add_full;
    logic [64:0] w_sub_full;
    logic [63:0] w_result;
    logic        w_alu_n;
    logic        w_alu_z;
    logic        w_alu_v;
    logic        w_alu_c;

    logic        w_br_taken;
    logic [63:0] w_pc_next;

    // Instruction decode: control bits, immediate and branch offset
    always_comb begin
        w_reg_write  = 1'b0;
        w_reg2loc    = 1'b0;
        w_alu_src    = 1'b0;
        w_set_flags  = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_to_reg = 1'b0;
        w_alu_cntrl  = c_ALU_PASSB;
        w_imm        = 64'd0;
        w_offset     = 64'd0;
        w_is_b       = 1'b0;
        w_is_cbz     = 1'b0;
        w_is_blt     = 1'b0;

        if (bus.inst[31:22] == c_OP_ADDI) begin
            w_reg_write = 1'b1;
            w_alu_src   = 1'b1;
            w_alu_cntrl = c_ALU_ADD;
            w_imm       = {52'd0, bus.inst[21:10]};
        end else if (bus.inst[31:21] == c_OP_ADDS) begin
            w_reg_write = 1'b1;
            w_reg2loc   = 1'b1;
            w_set_flags = 1'b1;
            w_alu_cntrl = c_ALU_ADD;
        end else if (bus.inst[31:21] == c_OP_SUBS) begin
            w_reg_write = 1'b1;
            w_reg2loc   = 1'b1;
            w_set_flags = 1'b1;
            w_alu_cntrl = c_ALU_SUB;
`ifdef CPU_EXEC_CORE_ANDS_EN
        end else if (bus.inst[31:21] == c_OP_ANDS) begin
            w_reg_write = 1'b1;
            w_reg2loc   = 1'b1;
            w_set_flags = 1'b1;
            w_alu_cntrl = c_ALU_AND;
`endif
        end else if (bus.inst[31:21] == c_OP_LDUR) begin
            w_reg_write  = 1'b1;
            w_alu_src    = 1'b1;
            w_mem_read   = 1'b1;
            w_mem_to_reg = 1'b1;
            w_alu_cntrl  = c_ALU_ADD;
            w_imm        = {{55{bus.inst[20]}}, bus.inst[20:12]};
        end else if (bus.inst[31:21] == c_OP_STUR) begin
            // reg2loc stays 0 so the store data register Rt comes from inst[4:0]
            w_alu_src   = 1'b1;
            w_mem_write = 1'b1;
            w_alu_cntrl = c_ALU_ADD;
            w_imm       = {{55{bus.inst[20]}}, bus.inst[20:12]};
        end else if (bus.inst[31:26] == c_OP_B) begin
            w_is_b   = 1'b1;
            w_offset = {{38{bus.inst[25]}}, bus.inst[25:0]};
        end else if (bus.inst[31:24] == c_OP_CBZ) begin
            // ALU passes Rt through so its zero flag decides the branch
            w_is_cbz = 1'b1;
            w_offset = {{45{bus.inst[23]}}, bus.inst[23:5]};
        end else if ((bus.inst[31:24] == c_OP_BCOND) && (bus.inst[4:0] == c_COND_LT)) begin
            w_is_blt = 1'b1;
            w_offset = {{45{bus.inst[23]}}, bus.inst[23:5]};
        end
    end

    assign w_a        = bus.rd1;
    assign w_b        = w_alu_src ? w_imm : bus.rd2;
    assign w_add_full = {1'b0, w_a} + {1'b0, w_b};
    assign w_sub_full = {1'b0, w_a} + {1'b0, ~w_b} + 65'd1;

    // ALU result and combinational condition flags
    always_comb begin
        w_result = 64'd0;
        w_alu_c  = 1'b0;
        w_alu_v  = 1'b0;
        case (w_alu_cntrl)
            c_ALU_PASSB: w_result = w_b;
            c_ALU_ADD: begin
                w_result = w_add_full[63:0];
                w_alu_c  = w_add_full[64];
                w_alu_v  = (w_a[63] == w_b[63]) && (w_add_full[63] != w_a[63]);
            end
            c_ALU_SUB: begin
                w_result = w_sub_full[63:0];
                w_alu_c  = w_sub_full[64];
                w_alu_v  = (w_a[63] != w_b[63]) && (w_sub_full[63] != w_a[63]);
            end
            c_ALU_AND:   w_result = w_a & w_b;
            c_ALU_ORR:   w_result = w_a | w_b;
            c_ALU_EOR:   w_result = w_a ^ w_b;
            default:     w_result = 64'd0;
        endcase
        w_alu_n = w_result[63];
        w_alu_z = (w_result == 64'd0);
    end

    // Branch resolution: B.LT reads only the registered flags
    always_comb begin
        w_br_taken = 1'b0;
        if (w_is_b) begin
            w_br_taken = 1'b1;
        end else if (w_is_cbz) begin
            w_br_taken = w_alu_z;
        end else if (w_is_blt) begin
            w_br_taken = (r_flag_n != r_flag_v);
        end
    end

    assign w_pc_next = w_br_taken ? (r_pc + (w_offset << 2)) : (r_pc + 64'd4);

    // Program counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // Condition flags load only on flag-setting instructions
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flag_n <= 1'b0;
            r_flag_z <= 1'b0;
            r_flag_v <= 1'b0;
            r_flag_c <= 1'b0;
        end else if (w_set_flags) begin
            r_flag_n <= w_alu_n;
            r_flag_z <= w_alu_z;
            r_flag_v <= w_alu_v;
            r_flag_c <= w_alu_c;
        end
    end

    assign bus.pc         = r_pc;
    assign bus.alu_result = w_result;
    assign bus.reg_write  = w_reg_write;
    assign bus.reg2loc    = w_reg2loc;
    assign bus.alu_src    = w_alu_src;
    assign bus.set_flags  = w_set_flags;
    assign bus.mem_write  = w_mem_write;
    assign bus.mem_read   = w_mem_read;
    assign bus.mem_to_reg = w_mem_to_reg;
    assign bus.br_taken   = w_br_taken;
    assign bus.alu_cntrl  = w_alu_cntrl;
    assign bus.flag_n     = r_flag_n;
    assign bus.flag_z     = r_flag_z;
    assign bus.flag_v     = r_flag_v;
    assign bus.flag_c     = r_flag_c;

endmodule
`default_nettype wire

// File: tb/tb_cpu_exec_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_exec_core
//  Description : Self-checking bench for cpu_exec_core: table of decode/ALU
//                vectors plus PC, branch, flag and reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_exec_core;

    localparam logic [63:0] c_RESET_PC = 64'h0;

    localparam logic [31:0] c_NOP      = 32'h0000_0000;
    localparam logic [31:0] c_ADDS     = 32'hAB00_0000;
    localparam logic [31:0] c_SUBS     = 32'hEB00_0000;
    localparam logic [31:0] c_B_M2     = 32'h17FF_FFFE;
    localparam logic [31:0] c_CBZ_3    = 32'hB400_0060;
    localparam logic [31:0] c_BLT_2    = 32'h5400_004B;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    cpu_exec_core_if bus ();

    cpu_exec_core #(.RESET_PC(c_RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic [63:0] exp_res;
        logic [10:0] exp_ctrl;   // {rw,r2l,asrc,sf,mw,mr,m2r,br,alu_cntrl[2:0]}
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b);
        bus.inst = i;
        bus.rd1  = a;
        bus.rd2  = b;
    endtask

    function automatic logic [10:0] ctrl_now();
        return {bus.reg_write, bus.reg2loc, bus.alu_src, bus.set_flags,
                bus.mem_write, bus.mem_read, bus.mem_to_reg, bus.br_taken, bus.alu_cntrl};
    endfunction

    function automatic logic [3:0] flags_now();
        return {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c};
    endfunction

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{c_NOP,        64'h1234, 64'h77,   64'h77,   {8'b0000_0000, 3'b000}};
        vecs[1]  = '{32'h9104_8C00, 64'd100,  64'hDEAD, 64'd391,  {8'b1010_0000, 3'b010}};
        vecs[2]  = '{32'h913F_FC00, 64'd1,    64'd0,    64'h1000, {8'b1010_0000, 3'b010}};
        vecs[3]  = '{c_ADDS, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, {8'b1101_0000, 3'b010}};
        vecs[4]  = '{c_SUBS,       64'd5,    64'd5,    64'd0,    {8'b1101_0000, 3'b011}};
        vecs[5]  = '{c_SUBS,       64'd0,    64'd1,    64'hFFFF_FFFF_FFFF_FFFF, {8'b1101_0000, 3'b011}};
        vecs[6]  = '{32'hF85F_8000, 64'd100,  64'h33,   64'd92,   {8'b1010_0110, 3'b010}};
        vecs[7]  = '{32'hF81F_8000, 64'd100,  64'h33,   64'd92,   {8'b0010_1000, 3'b010}};
        vecs[8]  = '{c_B_M2,       64'd9,    64'h55,   64'h55,   {8'b0000_0001, 3'b000}};
        vecs[9]  = '{c_CBZ_3,      64'd9,    64'd0,    64'd0,    {8'b0000_0001, 3'b000}};
        vecs[10] = '{c_CBZ_3,      64'd9,    64'd7,    64'd7,    {8'b0000_0000, 3'b000}};
`ifdef CPU_EXEC_CORE_ANDS_EN
        vecs[11] = '{32'hEA00_0000, 64'hF0F0, 64'hFF00, 64'hF000, {8'b1101_0000, 3'b100}};
`else
        vecs[11] = '{32'hEA00_0000, 64'hF0F0, 64'hFF00, 64'hFF00, {8'b0000_0000, 3'b000}};
`endif
        vecs[12] = '{32'hFFFF_FFFF, 64'd1,    64'hABC,  64'hABC,  {8'b0000_0000, 3'b000}};

        // Reset asserted across clock edges
        reset = 1'b0;
        drive(c_NOP, 64'd0, 64'd0);
        repeat (2) @(posedge clk);
        #2;
        check("reset_pc", bus.pc, c_RESET_PC);
        check("reset_flags", {60'd0, flags_now()}, 64'd0);

        @(negedge clk);
        reset = 1'b1;
        #1;
        check("release_pc", bus.pc, 64'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("nop_pc_%0d", k), bus.pc, 64'(4 * k));
        end
        check("nop_flags", {60'd0, flags_now()}, 64'd0);

        // Decode / ALU vector table
        for (int v = 0; v < 13; v++) begin
            @(negedge clk);
            drive(vecs[v].inst, vecs[v].rd1, vecs[v].rd2);
            #2;
            check($sformatf("vec%0d_result", v), bus.alu_result, vecs[v].exp_res);
            check($sformatf("vec%0d_ctrl", v), {53'd0, ctrl_now()}, {53'd0, vecs[v].exp_ctrl});
        end

        // Restart from reset to get a known PC
        @(negedge clk);
        reset = 1'b0;
        drive(c_NOP, 64'd0, 64'd0);
        #1;
        @(negedge clk);
        reset = 1'b1;
        repeat (4) tick();
        check("seq_pc16", bus.pc, 64'd16);

        // Branches
        drive(c_B_M2, 64'd0, 64'd0);
        #1;
        check("b_taken", {63'd0, bus.br_taken}, 64'd1);
        tick();
        check("b_pc", bus.pc, 64'd8);
        drive(c_CBZ_3, 64'd0, 64'd0);
        tick();
        check("cbz_taken_pc", bus.pc, 64'd20);
        drive(c_CBZ_3, 64'd0, 64'd7);
        #1;
        check("cbz_not_taken", {63'd0, bus.br_taken}, 64'd0);
        tick();
        check("cbz_nt_pc", bus.pc, 64'd24);

        // Flag updates {N,Z,V,C}
        drive(c_ADDS, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        tick();
        check("adds_carry_flags", {60'd0, flags_now()}, {60'd0, 4'b0101});
        drive(c_ADDS, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        tick();
        check("adds_ovf_flags", {60'd0, flags_now()}, {60'd0, 4'b1010});
        drive(c_SUBS, 64'd5, 64'd5);
        tick();
        check("subs_eq_flags", {60'd0, flags_now()}, {60'd0, 4'b0101});
        drive(c_SUBS, 64'd0, 64'd1);
        tick();
        check("subs_neg_flags", {60'd0, flags_now()}, {60'd0, 4'b1000});
        check("pre_blt_pc", bus.pc, 64'd40);

        // B.LT with N!=V
        drive(c_BLT_2, 64'd0, 64'd0);
        #1;
        check("blt_taken", {63'd0, bus.br_taken}, 64'd1);
        tick();
        check("blt_pc", bus.pc, 64'd48);
        check("blt_flags_hold", {60'd0, flags_now()}, {60'd0, 4'b1000});

        // B.LT with N==V
        drive(c_ADDS, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        tick();
        drive(c_BLT_2, 64'd0, 64'd0);
        #1;
        check("blt_not_taken", {63'd0, bus.br_taken}, 64'd0);
        tick();
        check("blt_nt_pc", bus.pc, 64'd56);
        check("blt_nt_flags", {60'd0, flags_now()}, {60'd0, 4'b1010});

        // Reset mid-operation with a pending flag update
        drive(c_ADDS, 64'd0, 64'd0);
        reset = 1'b0;
        #1;
        check("async_rst_pc", bus.pc, c_RESET_PC);
        check("async_rst_flags", {60'd0, flags_now()}, 64'd0);
        tick();
        check("rst_hold_pc", bus.pc, c_RESET_PC);
        check("rst_hold_flags", {60'd0, flags_now()}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(c_NOP, 64'd0, 64'd0);
        tick();
        check("post_rst_pc", bus.pc, 64'd4);
        check("post_rst_flags", {60'd0, flags_now()}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_exec_core.md
CPU_EXEC_CORE -- requirements
Module: cpu_exec_core

Interface
REQ-001 Parameter: RESET_PC, default 64'h0, PC value loaded on reset.
REQ-002 Port: clk, input, 1, single clock; all state updates on rising edge.
REQ-003 Port: reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-004 Port: inst, input, 32, current instruction word fetched at pc.
REQ-005 Port: rd1, input, 64, register-file read data for Rn (inst[9:5]).
REQ-006 Port: rd2, input, 64, register-file read data for the register selected by reg2loc.
REQ-007 Port: pc, output, 64, current program counter.
REQ-008 Port: alu_result, output, 64, ALU output, used as memory address or write-back value.
REQ-009 Ports: reg_write, reg2loc, alu_src, set_flags, mem_write, mem_read, mem_to_reg, br_taken, outputs, 1 each, control bits.
REQ-010 Port: alu_cntrl, output, 3, ALU operation selector.
REQ-011 Ports: flag_n, flag_z, flag_v, flag_c, outputs, 1 each, registered condition flags.

Function
REQ-012 ALU operation: A=rd1; B=alu_src?imm:rd2; alu_cntrl 000=pass B, 010=A+B, 011=A-B (A+~B+1), 100=AND, 101=OR, 110=XOR; other codes give result 0.
REQ-013 ALU combinational flags: zero=(result==0); negative=result[63]; carry=carry-out of 64-bit add or subtract, 0 for other ops; overflow=signed overflow for add/sub, 0 otherwise.
REQ-014 Immediates: ADDI uses zero-extended inst[21:10]; LDUR/STUR use sign-extended inst[20:12].
REQ-015 Decode: ADDI inst[31:22]=1001000100 -> reg_write=1, alu_src=1, alu_cntrl=010.
REQ-016 Decode: ADDS inst[31:21]=10101011000 -> reg_write=1, reg2loc=1, alu_cntrl=010, set_flags=1.
REQ-017 Decode: SUBS inst[31:21]=11101011000 -> as ADDS but alu_cntrl=011.
REQ-018 Decode: LDUR inst[31:21]=11111000010 -> reg_write=1, alu_src=1, alu_cntrl=010, mem_read=1, mem_to_reg=1.
REQ-019 Decode: STUR inst[31:21]=11111000000 -> reg2loc=0 (Rt=inst[4:0]), alu_src=1, alu_cntrl=010, mem_write=1.
REQ-020 Decode: B inst[31:26]=000101 -> br_taken=1, offset=sign-extended inst[25:0].
REQ-021 Decode: CBZ inst[31:24]=10110100 -> reg2loc=0, alu_cntrl=000; br_taken=ALU combinational zero; offset=sign-extended inst[23:5].
REQ-022 Decode: B.LT inst[31:24]=01010100 and inst[4:0]=01011 -> br_taken=(flag_n != flag_v), using registered flags; offset=sign-extended inst[23:5].
REQ-023 Unrecognised encoding: all control bits 0 (NOP), alu_cntrl=000, PC advances by 4.
REQ-024 PC update each rising edge: pc <= br_taken ? pc + (offset<<2) : pc + 4; 64-bit wrap-around, no overflow detection.
REQ-025 Flags load ALU N/Z/V/C on rising edge only when set_flags=1; otherwise hold.
REQ-026 Branch and flag-setting in the same cycle are impossible; B.LT always sees flags from an earlier instruction.

Reset
REQ-027 reset=0 asynchronously forces pc=RESET_PC and all four flags to 0; the released state takes effect on the first rising edge after reset returns to 1.
REQ-028 Reset asserted mid-operation discards any pending PC/flag update; control outputs stay combinational from inst.

Configuration
REQ-029 Macro CPU_EXEC_CORE_ANDS_EN: when defined, ANDS inst[31:21]=11101010000 decodes as reg_write=1, reg2loc=1, alu_cntrl=100, set_flags=1 (C=V=0); when undefined, ANDS is a NOP per REQ-023.

Verification
REQ-030 Reset low, then high with inst=NOP -> pc=0, then 4, 8, 12 on successive edges; flags 0.
REQ-031 ADDS rd1=64'h7FFF_FFFF_FFFF_FFFF, rd2=1 -> alu_result=64'h8000_0000_0000_0000; after edge N=1, V=1, Z=0, C=0.
REQ-032 SUBS rd1=5, rd2=5 -> alu_result=0; after edge Z=1, C=1, N=0, V=0.
REQ-033 pc=16, B with imm26=-2 -> br_taken=1, next pc=8; CBZ with rd2=0 and imm19=3 at pc=8 -> next pc=20; CBZ with rd2=7 -> next pc=pc+4.
REQ-034 Flags N=1, V=0, then B.LT imm19=2 at pc=40 -> pc=48; with N=V=1 -> pc=44.
REQ-035 LDUR imm9=-8, rd1=100 -> alu_result=92, mem_read=1, mem_to_reg=1, reg_write=1; STUR same -> mem_write=1, reg_write=0.
